// File: rtl/ttt_pkg.sv
// -----------------------------------------------------------------------------
// ttt_pkg
// Shared definitions for the tic-tac-toe move sequencer and its neighbours.
//   - Cell encodings (two bits per board cell).
//   - Sequencer state enum.
//   - Board size and small helpers for mapping the 4-bit cell select.
// No ports (package).
// -----------------------------------------------------------------------------
package ttt_pkg;

    localparam int NUM_CELLS = 9;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_P1    = 2'b01;
    localparam logic [1:0] CELL_P2    = 2'b10;

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Cell selects are 1-based; 0 and 10..15 do not name a cell.
    function automatic logic sel_valid(input logic [3:0] sel);
        return (sel >= 4'd1) && (sel <= 4'd9);
    endfunction

    // One-hot enable for a 0-based cell index (bit k = cell k+1).
    function automatic logic [NUM_CELLS-1:0] cell_onehot(input logic [3:0] idx);
        return NUM_CELLS'(1) << idx;
    endfunction

endpackage

// File: rtl/move_sequencer_if.sv
// -----------------------------------------------------------------------------
// move_sequencer_if
// Handshake between the move sequencer and the illegal-move detector.
//   PL1_en       [8:0]  one-hot player-1 enable (bit k = cell k+1)
//   PL2_en       [8:0]  one-hot player-2 enable
//   illegal_move        combinational verdict for the enable currently driven
// Modports:
//   master - the sequencer (drives enables, reads the verdict)
//   slave  - the detector  (reads enables, drives the verdict)
// -----------------------------------------------------------------------------
interface move_sequencer_if;
    import ttt_pkg::*;

    logic [NUM_CELLS-1:0] PL1_en;
    logic [NUM_CELLS-1:0] PL2_en;
    logic                 illegal_move;

    modport master (output PL1_en, output PL2_en, input illegal_move);
    modport slave  (input PL1_en, input PL2_en, output illegal_move);

endinterface

// File: rtl/move_sequencer_pulse_stretcher.sv
// -----------------------------------------------------------------------------
// pulse_stretcher
// Holds its output high for HOLD cycles after a load. A new load restarts the
// hold; clear drops the output on the next edge and wins over load.
// Ports:
//   clock  in   system clock
//   reset  in   synchronous, active-high reset
//   load   in   start (or restart) the hold
//   clear  in   cancel the hold
//   pulse  out  high while the hold is running
// -----------------------------------------------------------------------------
module pulse_stretcher #(
    parameter int HOLD = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic clear,
    output logic pulse
);

    localparam int CW = $clog2(HOLD + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = CW'(HOLD);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Load value HOLD gives exactly HOLD cycles of nonzero count.
    assign pulse = (cnt_q != '0);

endmodule

// File: rtl/move_sequencer.sv
// -----------------------------------------------------------------------------
// move_sequencer
// Turn/board sequencer in front of the illegal-move detector. Owns the nine
// board cells and the current turn. A play strobe from the player on move with
// a valid cell select produces a one-cycle one-hot enable toward the detector;
// the detector's verdict then either commits the mark and passes the turn, or
// raises the stretched illegal indicator and keeps the turn.
//
// Optional build macro: MOVE_TIMEOUT_EN
//   When defined, an idle counter in WAIT forfeits the turn after
//   TIMEOUT_CYCLES cycles and the timeout_pulse output is present.
//
// Ports:
//   clock, reset         clock and synchronous active-high reset
//   p1_play, p2_play     single-cycle move strobes
//   sel [3:0]            target cell, 1..9
//   game_over            level from the win detector
//   det (master)         PL1_en/PL2_en out, illegal_move in
//   pos1..pos9 [1:0]     cell states (00 empty, 01 P1, 10 P2)
//   turn                 0 = player 1 to move, 1 = player 2
//   illegal_ind          stretched rejected-move indicator
//   move_ok              one-cycle pulse on commit
//   timeout_pulse        one-cycle pulse on forfeit (MOVE_TIMEOUT_EN only)
//   no_space             all cells occupied, registered
// -----------------------------------------------------------------------------
module move_sequencer
    import ttt_pkg::*;
#(
`ifdef MOVE_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES = 500_000_000,
`endif
    parameter int FIRST_PLAYER = 0,
    parameter int ILLEGAL_HOLD = 50_000_000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    p1_play,
    input  logic                    p2_play,
    input  logic [3:0]              sel,
    input  logic                    game_over,
    move_sequencer_if.master        det,
    output logic [1:0]              pos1,
    output logic [1:0]              pos2,
    output logic [1:0]              pos3,
    output logic [1:0]              pos4,
    output logic [1:0]              pos5,
    output logic [1:0]              pos6,
    output logic [1:0]              pos7,
    output logic [1:0]              pos8,
    output logic [1:0]              pos9,
    output logic                    turn,
    output logic                    illegal_ind,
    output logic                    move_ok,
`ifdef MOVE_TIMEOUT_EN
    output logic                    timeout_pulse,
`endif
    output logic                    no_space
);

    state_e               state_q, state_d;
    logic                 turn_q, turn_d;
    logic [1:0]           board_q [NUM_CELLS];
    logic [1:0]           board_d [NUM_CELLS];
    logic [3:0]           idx_q, idx_d;
    logic [NUM_CELLS-1:0] pl1_en_q, pl1_en_d;
    logic [NUM_CELLS-1:0] pl2_en_q, pl2_en_d;
    logic                 move_ok_q, move_ok_d;
    logic                 no_space_q, no_space_d;

    logic                 active;
    logic                 full;
    logic                 ill_load;
    logic                 ill_clear;

`ifdef MOVE_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0]        tc_q, tc_d;
    logic                 timeout_q, timeout_d;
    logic                 wait_idle;
`endif

    always_comb begin
        state_d   = state_q;
        turn_d    = turn_q;
        board_d   = board_q;
        idx_d     = idx_q;
        pl1_en_d  = '0;
        pl2_en_d  = '0;
        move_ok_d = 1'b0;
        ill_load  = 1'b0;
        ill_clear = 1'b0;

        // Only the strobe of the player on move counts; the other is ignored.
        active = turn_q ? p2_play : p1_play;

        full = 1'b1;
        for (int k = 0; k < NUM_CELLS; k++) begin
            if (board_q[k] == CELL_EMPTY) begin
                full = 1'b0;
            end
        end
        no_space_d = full;

        unique case (state_q)
            WAIT: begin
                if (game_over || no_space_q) begin
                    state_d = DONE;
                end else if (active) begin
                    if (sel_valid(sel)) begin
                        idx_d = sel - 4'd1;
                        if (turn_q) begin
                            pl2_en_d = cell_onehot(sel - 4'd1);
                        end else begin
                            pl1_en_d = cell_onehot(sel - 4'd1);
                        end
                        state_d = CHECK;
                    end else begin
                        ill_load = 1'b1;
                    end
                end
            end
            CHECK: begin
                // The verdict refers to the enable registered last edge.
                if (!det.illegal_move) begin
                    board_d[idx_q] = turn_q ? CELL_P2 : CELL_P1;
                    turn_d         = ~turn_q;
                    move_ok_d      = 1'b1;
                    ill_clear      = 1'b1;
                end else begin
                    ill_load = 1'b1;
                end
                // A game_over seen mid-check lets the check finish first.
                state_d = game_over ? DONE : WAIT;
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = WAIT;
            end
        endcase

`ifdef MOVE_TIMEOUT_EN
        // Counts only while idle in WAIT; an accepted strobe or leaving WAIT
        // restarts it, and a forfeit restarts it for the new player.
        wait_idle = (state_q == WAIT) && !game_over && !no_space_q
                    && !(active && sel_valid(sel));
        tc_d      = '0;
        timeout_d = 1'b0;
        if (wait_idle) begin
            if (tc_q == TW'(TIMEOUT_CYCLES - 1)) begin
                turn_d    = ~turn_q;
                timeout_d = 1'b1;
            end else begin
                tc_d = tc_q + TW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= WAIT;
            turn_q     <= 1'(FIRST_PLAYER);
            idx_q      <= '0;
            pl1_en_q   <= '0;
            pl2_en_q   <= '0;
            move_ok_q  <= 1'b0;
            no_space_q <= 1'b0;
            for (int k = 0; k < NUM_CELLS; k++) begin
                board_q[k] <= CELL_EMPTY;
            end
        end else begin
            state_q    <= state_d;
            turn_q     <= turn_d;
            idx_q      <= idx_d;
            pl1_en_q   <= pl1_en_d;
            pl2_en_q   <= pl2_en_d;
            move_ok_q  <= move_ok_d;
            no_space_q <= no_space_d;
            board_q    <= board_d;
        end
    end

`ifdef MOVE_TIMEOUT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            tc_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            tc_q      <= tc_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_pulse = timeout_q;
`endif

    pulse_stretcher #(
        .HOLD (ILLEGAL_HOLD)
    ) u_illegal_stretch (
        .clock (clock),
        .reset (reset),
        .load  (ill_load),
        .clear (ill_clear),
        .pulse (illegal_ind)
    );

    assign det.PL1_en = pl1_en_q;
    assign det.PL2_en = pl2_en_q;
    assign turn       = turn_q;
    assign move_ok    = move_ok_q;
    assign no_space   = no_space_q;
    assign pos1       = board_q[0];
    assign pos2       = board_q[1];
    assign pos3       = board_q[2];
    assign pos4       = board_q[3];
    assign pos5       = board_q[4];
    assign pos6       = board_q[5];
    assign pos7       = board_q[6];
    assign pos8       = board_q[7];
    assign pos9       = board_q[8];

endmodule

// File: doc/move_sequencer.md
Name: move_sequencer

Overview:
- Turn/board sequencer that sits directly upstream of, and consumes the result from, the illegal-move detector.
- Owns the nine 2-bit board cell registers and the current-turn state.
- Converts a player's play strobe plus position select into a one-cycle one-hot enable (PL1_en/PL2_en) for the detector.
- Samples the detector's illegal_move reply, then either commits the mark and alternates turns, or flags the move and keeps the turn.

Parameters:
- FIRST_PLAYER, 0, player to move after reset (0 = player 1, 1 = player 2).
- ILLEGAL_HOLD, 50_000_000, cycles the illegal indicator stays high after a rejected move; must be ≥1.
- TIMEOUT_CYCLES, 500_000_000, idle cycles before turn forfeit; used only with MOVE_TIMEOUT_EN.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- p1_play  in  1  player-1 move strobe, single-cycle, already debounced
- p2_play  in  1  player-2 move strobe, single-cycle, already debounced
- sel  in  4  target cell; 1..9 valid, 0 and 10..15 invalid
- illegal_move  in  1  combinational reply from detector for the current PL1_en/PL2_en
- game_over  in  1  winner found (from win detector); level
- PL1_en  out  9  one-hot player-1 enable, bit k = cell k+1
- PL2_en  out  9  one-hot player-2 enable
- pos1..pos9  out  2 each  cell state: 00 empty, 01 player 1, 10 player 2; 11 never produced
- turn  out  1  0 = player 1 to move, 1 = player 2
- illegal_ind  out  1  stretched rejected-move indicator
- move_ok  out  1  one-cycle pulse on commit
- no_space  out  1  all nine cells occupied, registered

Behaviour:
- Reset values:
  - PL1_en = PL2_en = 0
  - all pos = 00
  - turn = FIRST_PLAYER
  - illegal_ind = 0, move_ok = 0, no_space = 0
  - state WAIT, counters 0
- Reset mid-operation aborts everything in the next cycle.
- WAIT state:
  - The active strobe is p1_play if turn = 0, p2_play if turn = 1. A strobe from the wrong player is ignored with no indicator.
  - If p1_play and p2_play arrive together, only the one matching turn is used.
  - Active strobe with a valid sel: latch index, drive the matching PLx_en one-hot on the next edge, go to CHECK.
  - Active strobe with an invalid sel: load the illegal counter (illegal_ind high), stay in WAIT, no enable driven.
- CHECK state (exactly one cycle; PLx_en high only here):
  - illegal_move = 0: at the next edge write 01 or 10 into the cell, toggle turn, pulse move_ok, clear PLx_en, go to WAIT.
  - illegal_move = 1: cell unchanged, turn unchanged, load the illegal counter, clear PLx_en, go to WAIT.
- Latency: strobe at edge N, enable during cycle N+1, cell and turn updated at edge N+2.
- Throughput: a strobe arriving while in CHECK is dropped.
- illegal_ind:
  - Stays high for ILLEGAL_HOLD cycles.
  - A new rejection reloads the counter.
  - A successful commit clears it immediately.
- no_space: registered from all nine cells ≠ 00; updates one cycle after the ninth commit.
- DONE state:
  - Entered from WAIT when game_over = 1 or no_space = 1.
  - All strobes are ignored; enables are held at 0; board and turn are frozen.
  - Only reset leaves DONE.
- If game_over rises while in CHECK, the CHECK still completes, then the block goes to DONE.
- Invariant: at most one bit across PL1_en|PL2_en is ever high.

Optional Feature:
- Macro: MOVE_TIMEOUT_EN.
- Defined:
  - A counter runs while in WAIT and resets on any accepted strobe or on turn change.
  - On reaching TIMEOUT_CYCLES-1, turn toggles with no cell written.
  - Adds output timeout_pulse (1 bit), a one-cycle pulse on forfeit.
- Undefined: no counter, no timeout_pulse port; the turn waits indefinitely.

Decomposition:
- Shared package ttt_pkg holds:
  - cell encoding constants CELL_EMPTY = 2'b00, CELL_P1 = 2'b01, CELL_P2 = 2'b10
  - state enum WAIT / CHECK / DONE
  - NUM_CELLS = 9
- Sub-module pulse_stretcher (load, count to ILLEGAL_HOLD, clear) drives illegal_ind.
- Everything else (FSM, board registers, timeout counter) stays in move_sequencer.

Test Plan:
- Reset with FIRST_PLAYER=0; p1_play with sel=5 → PL1_en = 9'h010 for one cycle; with illegal_move=0, pos5 = 01, turn = 1 and move_ok pulses at edge N+2.
- Cell 5 holds 01; p2_play with sel=5 and the bench model driving illegal_move=1 → pos5 stays 01, turn stays 1, illegal_ind high for exactly ILLEGAL_HOLD cycles (set to 4).
- turn = 0; p2_play with sel=3 → no enable, no change. Same cycle p1_play and p2_play with sel=3 → only PL1_en = 9'h004 asserted.
- sel=0 and sel=12 with the correct player → illegal_ind set, no PLx_en asserted, board unchanged.
- Nine alternating legal moves → no_space = 1 one cycle after the last commit; a further strobe is ignored. A separate run asserting game_over after 5 moves freezes the board; reset restores all outputs to reset values.
- MOVE_TIMEOUT_EN with TIMEOUT_CYCLES=8; no strobe → turn toggles after 8 cycles and timeout_pulse = 1 for one cycle.
